// File: rtl/event_sense_counter_pkg.sv
// Shared types and constants for the clock-recovery front end.
package clks_alot_p;

  localparam int COUNTER_WIDTH     = 16;
  localparam int LOCK_STREAK_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } lock_state_e;

endpackage

// File: rtl/event_sense_counter_sense_synchronizer.sv
// Synchroniser chain for the asynchronous sensed clock, plus history flop and
// registered edge detect. While clear is high the outputs are held at zero.
module sense_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic sense,
  output logic sense_event,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   history;
  logic                   sync_out;

  assign sync_out = sync_chain[SYNC_STAGES-1];

  // Stage: metastability chain, then history and registered edge/level.
  // History always follows the synchronised level, so leaving IDLE with the
  // input already high produces no edge.
  always_ff @(posedge clk) begin
    if (srst) begin
      sync_chain  <= '0;
      history     <= 1'b0;
      sense_event <= 1'b0;
      level       <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], sense};
      history    <= sync_out;
      if (clear) begin
        sense_event <= 1'b0;
        level       <= 1'b0;
      end else begin
        sense_event <= sync_out ^ history;
        level       <= sync_out;
      end
    end
  end

endmodule

// File: rtl/event_sense_counter.sv
// Clock-recovery front end: synchronised edge events, saturating rate counter
// with capture on accepted events, and a lock-tracking state machine.
module event_sense_counter #(
  parameter int COUNTER_WIDTH = clks_alot_p::COUNTER_WIDTH,
  parameter int SYNC_STAGES   = 2,
  parameter int LOCK_COUNT    = 4
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic                     enable_i,
  input  logic                     sense_i,
  input  logic                     accept_i,
  input  logic                     over_violation_i,
  input  logic                     under_violation_i,
  output logic                     event_o,
  output logic                     primary_clk_o,
  output logic [COUNTER_WIDTH-1:0] current_rate_counter_o,
  output logic [COUNTER_WIDTH-1:0] captured_rate_o,
  output logic                     captured_valid_o,
  output logic                     saturated_o,
  output logic                     lock_o,
  output logic [1:0]               lock_state_o
);

  import clks_alot_p::*;

  localparam logic [LOCK_STREAK_WIDTH-1:0] LOCK_TARGET = LOCK_COUNT[LOCK_STREAK_WIDTH-1:0];

  lock_state_e                  state, state_next;
  logic [LOCK_STREAK_WIDTH-1:0] streak, streak_next, streak_inc;
  logic [COUNTER_WIDTH-1:0]     count, captured;
  logic                         captured_valid, sat_q;
  logic                         sense_event, level;
  logic                         clr, saturated, sat_rise, accepted, clean, violation;

  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Disabling clears datapath state on the same edge the FSM returns to IDLE.
  assign clr = !enable_i || (state == IDLE);

  sense_synchronizer #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk         (clk_i),
    .srst        (srst_i),
    .clear       (clr),
    .sense       (sense_i),
    .sense_event (sense_event),
    .level       (level)
  );

  assign saturated  = &count;
  assign sat_rise   = saturated && !sat_q;
  assign accepted   = sense_event && accept_i;
  assign clean      = accepted && !over_violation_i && !under_violation_i && !saturated;
  assign violation  = (sense_event && (over_violation_i || under_violation_i)) || sat_rise;
  assign streak_inc = streak + 1'b1;

  // Stage: rate counter and capture register, updated from the event stage.
  always_ff @(posedge clk_i) begin
    if (srst_i || clr) begin
      count          <= '0;
      captured       <= '0;
      captured_valid <= 1'b0;
      sat_q          <= 1'b0;
    end else begin
      sat_q          <= saturated;
      captured_valid <= accepted;
      if (accepted) begin
        count    <= COUNTER_WIDTH'(1);
        captured <= count;
      end else begin
        count <= sat_inc(count);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= state_next;
      streak <= streak_next;
    end
  end

  always_comb begin
    state_next  = state;
    streak_next = streak;
    unique case (state)
      IDLE: begin
        streak_next = '0;
        if (enable_i) state_next = ACQUIRE;
      end
      ACQUIRE: begin
        if (violation) begin
          streak_next = '0;
        end else if (clean) begin
          streak_next = streak_inc;
          if (streak_inc == LOCK_TARGET) state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (violation) state_next = LOST;
      end
      LOST: begin
        streak_next = '0;
        state_next  = ACQUIRE;
      end
    endcase
    if (!enable_i) begin
      state_next  = IDLE;
      streak_next = '0;
    end
  end

  always_comb begin
    lock_o       = (state == LOCKED);
    lock_state_o = state;
  end

  assign event_o                = sense_event;
  assign primary_clk_o          = level;
  assign current_rate_counter_o = count;
  assign captured_rate_o        = captured;
  assign captured_valid_o       = captured_valid;
  assign saturated_o            = saturated;

endmodule
